// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the multicycle restoring divider.
//   - DIV_WIDTH : default operand/result width (iteration count equals width)
//   - DIV_CNT_W : iteration counter width for the default width
//   - div_state_e : controller state encoding (IDLE/CALC/FIX/DONE)
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Ports:
//   i_rem  - partial remainder (always < i_div on entry)
//   i_quo  - quotient/dividend shift register
//   i_div  - divisor magnitude
//   o_rem  - next partial remainder
//   o_quo  - next quotient/dividend shift register
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // Shifted remainder is < 2*divisor, so a WIDTH+1 bit subtraction is
  // enough for its top bit to be a reliable sign of the trial result.
  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, i_div};
    if (!w_trial[WIDTH]) begin
      o_rem = w_trial[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shift[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multicycle restoring divider for DIV (and optionally DIVU).
// Quotient is written to LO, remainder to HI, both truncating toward zero
// with the remainder taking the dividend's sign.
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous active-high reset
//   DivStart    - start request, sampled only in IDLE
//   DivUnsigned - (only with DIV_UNSIGNED_EN) treat operands as unsigned
//   A, B        - dividend / divisor (two's complement)
//   HI, LO      - remainder / quotient, registered
//   DivBusy     - high in CALC and FIX
//   DivDone     - one-cycle completion pulse (DONE state)
//   DivZero     - divide-by-zero flag, held until the next accepted start
// Configuration: define DIV_UNSIGNED_EN to add the DivUnsigned port.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivStart,
`ifdef DIV_UNSIGNED_EN
  input  logic             DivUnsigned,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivBusy,
  output logic             DivDone,
  output logic             DivZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       r_state;
  div_state_e       w_next;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_unsigned;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

`ifdef DIV_UNSIGNED_EN
  assign w_unsigned = DivUnsigned;
`else
  assign w_unsigned = 1'b0;
`endif

  // The most negative value maps to itself, which as an unsigned magnitude
  // is exactly 2^(WIDTH-1), so no special case is needed.
  assign w_a_mag  = (!w_unsigned && A[WIDTH-1]) ? -A : A;
  assign w_b_mag  = (!w_unsigned && B[WIDTH-1]) ? -B : B;
  assign w_b_zero = (B == '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_nx),
    .o_quo (w_quo_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    DivBusy = 1'b0;
    DivDone = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (DivStart) w_next = w_b_zero ? S_DONE : S_CALC;
      end
      S_CALC: begin
        DivBusy = 1'b1;
        if (w_last) w_next = S_FIX;
      end
      S_FIX: begin
        DivBusy = 1'b1;
        w_next  = S_DONE;
      end
      S_DONE: begin
        DivDone = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI      <= '0;
      LO      <= '0;
      DivZero <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (DivStart) begin
            if (w_b_zero) begin
              DivZero <= 1'b1;
            end else begin
              DivZero <= 1'b0;
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_div   <= w_b_mag;
              r_cnt   <= '0;
              r_neg_q <= !w_unsigned && (A[WIDTH-1] ^ B[WIDTH-1]);
              r_neg_r <= !w_unsigned && A[WIDTH-1];
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          LO <= r_neg_q ? -r_quo : r_quo;
          HI <= r_neg_r ? -r_rem : r_rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        DivStart;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        DivBusy;
  logic        DivDone;
  logic        DivZero;
`ifdef DIV_UNSIGNED_EN
  logic        DivUnsigned;
`endif

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .DivStart   (DivStart),
`ifdef DIV_UNSIGNED_EN
    .DivUnsigned(DivUnsigned),
`endif
    .A          (A),
    .B          (B),
    .HI         (HI),
    .LO         (LO),
    .DivBusy    (DivBusy),
    .DivDone    (DivDone),
    .DivZero    (DivZero)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  exp_t        sb[$];
  logic [31:0] m_lo = '0;
  logic [31:0] m_hi = '0;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] lo, input logic [31:0] hi, input logic z);
    exp_t e;
    e.lo = lo; e.hi = hi; e.zero = z;
    m_lo = lo; m_hi = hi;
    sb.push_back(e);
  endtask

  // Scoreboard: every DivDone pulse consumes one expected result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b0 && DivDone === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DivDone=1 expected no pending result");
      end else begin
        e = sb.pop_front();
        chk("LO", LO, e.lo);
        chk("HI", HI, e.hi);
        chk("DivZero", {31'b0, DivZero}, {31'b0, e.zero});
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((DivBusy || DivDone) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_result();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("result_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic uns,
                          input logic [31:0] lo, input logic [31:0] hi, input logic z);
    wait_idle();
    A = a;
    B = b;
`ifdef DIV_UNSIGNED_EN
    DivUnsigned = uns;
`else
    if (uns) chk("uns_unsupported", 32'd1, 32'd0);
`endif
    DivStart = 1'b1;
    push(lo, hi, z);
    @(negedge clk);
    DivStart = 1'b0;
    // operands must have been captured on the start edge
    A = $urandom;
    B = $urandom;
    wait_result();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int ia, ib;
    logic [31:0] ra, rb;
    int d0;

    tbl[0] = '{32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tbl[1] = '{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    tbl[2] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
    tbl[3] = '{32'd100,       32'd7,         32'd14,        32'd2};
    tbl[4] = '{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE};
    tbl[5] = '{32'd0,         32'd5,         32'd0,         32'd0};
    tbl[6] = '{32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 32'd0};
    tbl[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};

    reset = 1'b1;
    DivStart = 1'b0;
    A = '0;
    B = '0;
`ifdef DIV_UNSIGNED_EN
    DivUnsigned = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    chk("rst_busy", {31'b0, DivBusy}, 32'd0);
    chk("rst_done", {31'b0, DivDone}, 32'd0);
    chk("rst_zero", {31'b0, DivZero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 7/2 with exact busy/done timing; index j = state after edge k+j
    A = 32'd7;
    B = 32'd2;
    DivStart = 1'b1;
    push(32'd3, 32'd1, 1'b0);
    for (int j = 0; j <= 34; j++) begin
      @(negedge clk);
      if (j == 0) DivStart = 1'b0;
      chk("basic_busy", {31'b0, DivBusy}, (j <= 32) ? 32'd1 : 32'd0);
      chk("basic_done", {31'b0, DivDone}, (j == 33) ? 32'd1 : 32'd0);
    end
    wait_result();

    for (int i = 0; i < 8; i++)
      start_op(tbl[i].a, tbl[i].b, 1'b0, tbl[i].lo, tbl[i].hi, 1'b0);

    // Divide by zero right after the overflow vector
    wait_idle();
    A = 32'd5;
    B = 32'd0;
    DivStart = 1'b1;
    push(m_lo, m_hi, 1'b1);
    for (int j = 0; j <= 2; j++) begin
      @(negedge clk);
      if (j == 0) DivStart = 1'b0;
      chk("dz_busy", {31'b0, DivBusy}, 32'd0);
      chk("dz_done", {31'b0, DivDone}, (j == 0) ? 32'd1 : 32'd0);
      chk("dz_flag", {31'b0, DivZero}, 32'd1);
    end
    chk("dz_LO", LO, 32'h8000_0000);
    chk("dz_HI", HI, 32'd0);
    wait_result();

    // DivStart held high: one result, re-accepted only from IDLE
    d0 = done_seen;
    A = 32'd100;
    B = 32'd7;
    DivStart = 1'b1;
    push(32'd14, 32'd2, 1'b0);
    for (int j = 0; j <= 35; j++) begin
      @(negedge clk);
      if (j == 34) begin
        chk("hold_idle_busy", {31'b0, DivBusy}, 32'd0);
        chk("hold_idle_done", {31'b0, DivDone}, 32'd0);
      end
      if (j == 35) chk("hold_restart_busy", {31'b0, DivBusy}, 32'd1);
    end
    chk("hold_one_result", 32'(done_seen - d0), 32'd1);
    DivStart = 1'b0;
    push(32'd14, 32'd2, 1'b0);
    wait_result();
    chk("hold_two_results", 32'(done_seen - d0), 32'd2);

    // Random signed vectors against a reference model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      ia = ra;
      ib = rb;
      start_op(ra, rb, 1'b0, 32'(ia / ib), 32'(ia % ib), 1'b0);
    end

`ifdef DIV_UNSIGNED_EN
    start_op(32'hFFFF_FFFF, 32'd2, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    start_op(32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b0);
`endif

    // Reset in the middle of 1000/3, sampled on edge k+10
    wait_idle();
    A = 32'd1000;
    B = 32'd3;
    DivStart = 1'b1;
    push(32'd333, 32'd1, 1'b0);
    for (int j = 0; j <= 9; j++) begin
      @(negedge clk);
      if (j == 0) DivStart = 1'b0;
      if (j == 9) reset = 1'b1;
    end
    @(negedge clk);
    sb.delete();
    m_lo = '0;
    m_hi = '0;
    chk("mid_rst_HI", HI, 32'd0);
    chk("mid_rst_LO", LO, 32'd0);
    chk("mid_rst_busy", {31'b0, DivBusy}, 32'd0);
    chk("mid_rst_done", {31'b0, DivDone}, 32'd0);
    chk("mid_rst_zero", {31'b0, DivZero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'b0, DivBusy}, 32'd0);
    chk("post_rst_done", {31'b0, DivDone}, 32'd0);
    start_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
